// File: rtl/plat_collide_scan_if.sv
// Scan request/result bundle for plat_collide_scan.
// Macro PLAT_COLLIDE_HEAD_BUMP_EN adds the bump/bump_idx result signals.
interface plat_collide_scan_if #(
  parameter int unsigned PLATFORM_NUM_PER_BLOCK = 7,
  parameter int unsigned PHY_WIDTH              = 16,
  parameter int unsigned BLOCK_LEN_WIDTH        = 4
);
  logic                                         start;
  logic [PHY_WIDTH-1:0]                         player_x;
  logic [PHY_WIDTH-1:0]                         player_y;
  logic                                         falling;
  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_x;
  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]       plat_relative_y;
  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len;
  logic                                         block_switch;
  logic                                         busy;
  logic                                         done;
  logic                                         hit;
  logic                                         aborted;
  logic [2:0]                                   hit_idx;
  logic [PHY_WIDTH-1:0]                         land_y;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
  logic                                         bump;
  logic [2:0]                                   bump_idx;

  modport master (
    output start, player_x, player_y, falling, plat_relative_x, plat_relative_y,
           plat_len, block_switch,
    input  busy, done, hit, aborted, hit_idx, land_y, bump, bump_idx
  );
  modport slave (
    input  start, player_x, player_y, falling, plat_relative_x, plat_relative_y,
           plat_len, block_switch,
    output busy, done, hit, aborted, hit_idx, land_y, bump, bump_idx
  );
`else
  modport master (
    output start, player_x, player_y, falling, plat_relative_x, plat_relative_y,
           plat_len, block_switch,
    input  busy, done, hit, aborted, hit_idx, land_y
  );
  modport slave (
    input  start, player_x, player_y, falling, plat_relative_x, plat_relative_y,
           plat_len, block_switch,
    output busy, done, hit, aborted, hit_idx, land_y
  );
`endif
endinterface

// File: rtl/plat_collide_scan.sv
// Sequential landing scan: one platform per cycle against a snapshot of player/platforms.
// Macro PLAT_COLLIDE_HEAD_BUMP_EN adds head-bump detection for upward-moving players.
module plat_collide_scan #(
  parameter int unsigned PLATFORM_NUM_PER_BLOCK = 7,
  parameter int unsigned PHY_WIDTH              = 16,
  parameter int unsigned BLOCK_LEN_WIDTH        = 4,
  parameter int unsigned TILE_WIDTH             = 8,
  parameter int unsigned PLAYER_WIDTH           = 16,
  parameter int unsigned PLAYER_HEIGHT          = 24,
  parameter int unsigned SNAP_TOL               = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  plat_collide_scan_if.slave bus
);
  localparam int unsigned N     = PLATFORM_NUM_PER_BLOCK;
  localparam int unsigned SW    = PHY_WIDTH + 2;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t state, state_next;
  logic [IDX_W-1:0] idx, idx_next;

  logic [PHY_WIDTH-1:0]         snap_x, snap_y;
  logic                         snap_falling;
  logic [N*PHY_WIDTH-1:0]       snap_px, snap_py;
  logic [N*BLOCK_LEN_WIDTH-1:0] snap_len;

  logic                 best_hit, best_hit_next, cand_hit;
  logic [PHY_WIDTH-1:0] best_py, best_py_next, cand_py;
  logic [IDX_W-1:0]     best_idx, best_idx_next, cand_idx;

  logic                 busy_q, done_q, hit_q, aborted_q;
  logic                 hit_next, aborted_next;
  logic [IDX_W-1:0]     hit_idx_q, hit_idx_next;
  logic [PHY_WIDTH-1:0] land_q, land_next;
  logic                 accept;

  logic [PHY_WIDTH-1:0]       cur_px, cur_py;
  logic [BLOCK_LEN_WIDTH-1:0] cur_len;
  logic [SW-1:0] p_left, p_right, p_feet, pl_left, pl_right, pl_top, pl_snap;
  logic          x_ovl, land_match;

`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
  logic             best_bump, best_bump_next, cand_bump;
  logic [IDX_W-1:0] best_bidx, best_bidx_next, cand_bidx;
  logic             bump_q, bump_next;
  logic [IDX_W-1:0] bump_idx_q, bump_idx_next;
  logic [SW-1:0]    p_top;
  logic             bump_match;
`endif

  // Platform select from the snapshot
  always_comb begin
    cur_px  = '0;
    cur_py  = '0;
    cur_len = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (idx == IDX_W'(i)) begin
        cur_px  = snap_px[i*PHY_WIDTH +: PHY_WIDTH];
        cur_py  = snap_py[i*PHY_WIDTH +: PHY_WIDTH];
        cur_len = snap_len[i*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
      end
    end
  end

  // Geometry at SW bits so nothing wraps; strict overlap on x
  always_comb begin
    p_left     = SW'(snap_x);
    p_right    = SW'(snap_x) + SW'(PLAYER_WIDTH);
    p_feet     = SW'(snap_y) + SW'(PLAYER_HEIGHT);
    pl_left    = SW'(cur_px);
    pl_right   = SW'(cur_px) + SW'(cur_len) * SW'(TILE_WIDTH);
    pl_top     = SW'(cur_py);
    pl_snap    = SW'(cur_py) + SW'(SNAP_TOL);
    x_ovl      = (p_right > pl_left) && (p_left < pl_right);
    land_match = snap_falling && x_ovl && (pl_top <= p_feet) && (p_feet < pl_snap);
    // Strict '<' keeps the lower index on equal py
    cand_hit = best_hit;
    cand_py  = best_py;
    cand_idx = best_idx;
    if (land_match && (!best_hit || (cur_py < best_py))) begin
      cand_hit = 1'b1;
      cand_py  = cur_py;
      cand_idx = idx;
    end
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
    p_top      = SW'(snap_y);
    bump_match = !snap_falling && x_ovl && (pl_top <= p_top) && (p_top < pl_snap);
    cand_bump  = best_bump;
    cand_bidx  = best_bidx;
    if (bump_match && !best_bump) begin
      cand_bump = 1'b1;
      cand_bidx = idx;
    end
`endif
  end

  // Next state and next output values
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    accept        = 1'b0;
    best_hit_next = best_hit;
    best_py_next  = best_py;
    best_idx_next = best_idx;
    hit_next      = hit_q;
    hit_idx_next  = hit_idx_q;
    land_next     = land_q;
    aborted_next  = aborted_q;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
    best_bump_next = best_bump;
    best_bidx_next = best_bidx;
    bump_next      = bump_q;
    bump_idx_next  = bump_idx_q;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept        = 1'b1;
          state_next    = SCAN;
          idx_next      = '0;
          best_hit_next = 1'b0;
          best_py_next  = '0;
          best_idx_next = '0;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
          best_bump_next = 1'b0;
          best_bidx_next = '0;
`endif
        end
      end
      SCAN: begin
        if (bus.block_switch) begin
          state_next   = DONE;
          idx_next     = '0;
          hit_next     = 1'b0;
          hit_idx_next = '0;
          land_next    = '0;
          aborted_next = 1'b1;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
          bump_next     = 1'b0;
          bump_idx_next = '0;
`endif
        end else begin
          best_hit_next = cand_hit;
          best_py_next  = cand_py;
          best_idx_next = cand_idx;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
          best_bump_next = cand_bump;
          best_bidx_next = cand_bidx;
`endif
          if (idx == IDX_W'(N - 1)) begin
            state_next   = DONE;
            idx_next     = '0;
            hit_next     = cand_hit;
            hit_idx_next = cand_idx;
            land_next    = cand_py;
            aborted_next = 1'b0;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
            bump_next     = cand_bump;
            bump_idx_next = cand_bidx;
`endif
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      idx          <= '0;
      snap_x       <= '0;
      snap_y       <= '0;
      snap_falling <= 1'b0;
      snap_px      <= '0;
      snap_py      <= '0;
      snap_len     <= '0;
      best_hit     <= 1'b0;
      best_py      <= '0;
      best_idx     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      land_q       <= '0;
      aborted_q    <= 1'b0;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
      best_bump  <= 1'b0;
      best_bidx  <= '0;
      bump_q     <= 1'b0;
      bump_idx_q <= '0;
`endif
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      best_hit  <= best_hit_next;
      best_py   <= best_py_next;
      best_idx  <= best_idx_next;
      busy_q    <= (state_next != IDLE);
      done_q    <= (state_next == DONE);
      hit_q     <= hit_next;
      hit_idx_q <= hit_idx_next;
      land_q    <= land_next;
      aborted_q <= aborted_next;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
      best_bump  <= best_bump_next;
      best_bidx  <= best_bidx_next;
      bump_q     <= bump_next;
      bump_idx_q <= bump_idx_next;
`endif
      if (accept) begin
        snap_x       <= bus.player_x;
        snap_y       <= bus.player_y;
        snap_falling <= bus.falling;
        snap_px      <= bus.plat_relative_x;
        snap_py      <= bus.plat_relative_y;
        snap_len     <= bus.plat_len;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hit     = hit_q;
  assign bus.hit_idx = hit_idx_q;
  assign bus.land_y  = land_q;
  assign bus.aborted = aborted_q;
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
  assign bus.bump     = bump_q;
  assign bus.bump_idx = bump_idx_q;
`endif
endmodule

// File: tb/tb_plat_collide_scan.sv
// Scoreboard bench for plat_collide_scan: directed scans push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_plat_collide_scan;
  localparam int unsigned N = 7;

  typedef struct {
    logic        hit;
    logic [2:0]  idx;
    logic [15:0] land;
    logic        aborted;
    logic        bump;
    logic [2:0]  bump_idx;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  exp_t sb[$];

  always #5 sys_clk = ~sys_clk;

  plat_collide_scan_if #(.PLATFORM_NUM_PER_BLOCK(N), .PHY_WIDTH(16), .BLOCK_LEN_WIDTH(4)) bus ();

  plat_collide_scan #(.PLATFORM_NUM_PER_BLOCK(N)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic h, input int i, input int l, input logic ab,
                              input logic b, input int bi);
    exp_t e;
    e.hit = h; e.idx = 3'(i); e.land = 16'(l); e.aborted = ab;
    e.bump = b; e.bump_idx = 3'(bi);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge sys_clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done=1 with no scan outstanding (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hit", int'(bus.hit), int'(e.hit));
        check("hit_idx", int'(bus.hit_idx), int'(e.idx));
        check("land_y", int'(bus.land_y), int'(e.land));
        check("aborted", int'(bus.aborted), int'(e.aborted));
`ifdef PLAT_COLLIDE_HEAD_BUMP_EN
        check("bump", int'(bus.bump), int'(e.bump));
        check("bump_idx", int'(bus.bump_idx), int'(e.bump_idx));
`endif
      end
    end
  end

  task automatic set_plat(input int i, input int x, input int y, input int len);
    bus.plat_relative_x[i*16 +: 16] = 16'(x);
    bus.plat_relative_y[i*16 +: 16] = 16'(y);
    bus.plat_len[i*4 +: 4]          = 4'(len);
  endtask

  task automatic clear_plats();
    for (int i = 0; i < int'(N); i++) set_plat(i, 1000, 1000, 0);
  endtask

  // abort_at > 0: raise block_switch while scanning platform abort_at, then
  // try a start on the done cycle (must be ignored)
  task automatic run_scan(input int x, input int y, input logic f, input exp_t e,
                          input int abort_at, input logic bs_with_start);
    int   cyc;
    logic seen;
    @(negedge sys_clk);
    bus.player_x     = 16'(x);
    bus.player_y     = 16'(y);
    bus.falling      = f;
    bus.start        = 1'b1;
    bus.block_switch = bs_with_start;
    sb.push_back(e);
    @(negedge sys_clk);
    bus.start        = 1'b0;
    bus.block_switch = 1'b0;
    check("busy_rise", int'(bus.busy), 1);
    cyc  = 1;
    seen = bus.done;
    while (!seen && cyc < 20) begin
      if (abort_at > 0 && cyc == abort_at + 1) bus.block_switch = 1'b1;
      @(negedge sys_clk);
      bus.block_switch = 1'b0;
      cyc++;
      seen = bus.done;
    end
    check("done_latency", cyc, (abort_at > 0) ? abort_at + 2 : int'(N) + 1);
    if (abort_at > 0) bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    check("busy_after_done", int'(bus.busy), 0);
    check("hit_hold", int'(bus.hit), int'(e.hit));
  endtask

  task automatic run_reset_mid_scan();
    @(negedge sys_clk);
    bus.player_x = 16'd380;
    bus.player_y = 16'd176;
    bus.falling  = 1'b1;
    bus.start    = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_hit", int'(bus.hit), 0);
    check("rst_aborted", int'(bus.aborted), 0);
    check("rst_hit_idx", int'(bus.hit_idx), 0);
    check("rst_land_y", int'(bus.land_y), 0);
    repeat (10) @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start        = 1'b1;
    bus.block_switch = 1'b0;
    bus.player_x     = '0;
    bus.player_y     = '0;
    bus.falling      = 1'b0;
    clear_plats();
    // Reset held with start asserted: reset wins
    repeat (3) @(negedge sys_clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_hit", int'(bus.hit), 0);
    check("reset_land_y", int'(bus.land_y), 0);
    bus.start = 1'b0;
    sys_rst   = 1'b0;
    @(negedge sys_clk);

    // Basic landing, block_switch alongside the start is harmless
    set_plat(2, 370, 200, 10);
    run_scan(380, 176, 1'b1, mk(1, 2, 200, 0, 0, 0), 0, 1'b1);

    // Smaller py wins
    clear_plats();
    set_plat(1, 100, 300, 8);
    set_plat(4, 100, 304, 8);
    run_scan(120, 280, 1'b1, mk(1, 1, 300, 0, 0, 0), 0, 1'b0);

    // Equal py: lower index wins
    clear_plats();
    set_plat(3, 100, 300, 8);
    set_plat(5, 100, 300, 8);
    set_plat(6, 100, 302, 8);
    run_scan(120, 280, 1'b1, mk(1, 3, 300, 0, 0, 0), 0, 1'b0);

    // x edges of plat0 spanning [280,312)
    clear_plats();
    set_plat(0, 280, 200, 4);
    run_scan(264, 176, 1'b1, mk(0, 0, 0, 0, 0, 0), 0, 1'b0);
    run_scan(265, 176, 1'b1, mk(1, 0, 200, 0, 0, 0), 0, 1'b0);
    run_scan(311, 176, 1'b1, mk(1, 0, 200, 0, 0, 0), 0, 1'b0);
    run_scan(312, 176, 1'b1, mk(0, 0, 0, 0, 0, 0), 0, 1'b0);

    // Feet window [py, py+SNAP_TOL)
    run_scan(290, 184, 1'b1, mk(0, 0, 0, 0, 0, 0), 0, 1'b0);
    run_scan(290, 175, 1'b1, mk(0, 0, 0, 0, 0, 0), 0, 1'b0);
    run_scan(290, 183, 1'b1, mk(1, 0, 200, 0, 0, 0), 0, 1'b0);

    // Rising player under plat2: no landing, head bump when enabled
    clear_plats();
    set_plat(2, 370, 200, 10);
    run_scan(380, 200, 1'b0, mk(0, 0, 0, 0, 1, 2), 0, 1'b0);

    // Abort after a hit result is showing
    run_scan(380, 176, 1'b1, mk(1, 2, 200, 0, 0, 0), 0, 1'b0);
    run_scan(380, 176, 1'b1, mk(0, 0, 0, 1, 0, 0), 3, 1'b0);
    run_scan(380, 176, 1'b1, mk(1, 2, 200, 0, 0, 0), 0, 1'b0);

    // Reset mid-scan, then a fresh full scan
    run_reset_mid_scan();
    run_scan(380, 176, 1'b1, mk(1, 2, 200, 0, 0, 0), 0, 1'b0);

    repeat (4) @(negedge sys_clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/plat_collide_scan.md
PLAT_COLLIDE_SCAN -- requirements
Module: plat_collide_scan

Interface
REQ-001 SHALL have parameter PLATFORM_NUM_PER_BLOCK, default 7: platforms per block (N), 2..8.
REQ-002 SHALL have parameter PHY_WIDTH, default 16: coordinate width.
REQ-003 SHALL have parameter BLOCK_LEN_WIDTH, default 4: platform length field width.
REQ-004 SHALL have parameter TILE_WIDTH, default 8: pixels per platform length unit.
REQ-005 SHALL have parameters PLAYER_WIDTH 16, PLAYER_HEIGHT 24, SNAP_TOL 8 (pixels).
REQ-006 SHALL have: sys_clk  in  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have: sys_rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have: start  in  1  scan request, accepted only in IDLE.
REQ-009 SHALL have: player_x, player_y  in  PHY_WIDTH each  player top-left, block-relative.
REQ-010 SHALL have: falling  in  1  player vertical velocity is downward.
REQ-011 SHALL have: plat_relative_x, plat_relative_y  in  N*PHY_WIDTH; plat_len  in  N*BLOCK_LEN_WIDTH; platform i at slice i.
REQ-012 SHALL have: block_switch  in  1  platform set is changing.
REQ-013 SHALL have: busy, done, hit, aborted  out  1 each; hit_idx  out  3; land_y  out  PHY_WIDTH.

Function
REQ-014 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-015 IDLE with start=1 SHALL snapshot the player inputs, falling and all platform buses, clear the best-candidate register, and go to SCAN with idx=0.
REQ-016 SCAN SHALL evaluate one platform per cycle on the snapshot, idx 0..N-1, then go to DONE.
REQ-017 x overlap SHALL be strict: player_x+PLAYER_WIDTH > px AND player_x < px+len*TILE_WIDTH.
REQ-018 A landing match SHALL require falling=1, x overlap, and py <= player_y+PLAYER_HEIGHT < py+SNAP_TOL.
REQ-019 All sums SHALL be computed at PHY_WIDTH+2 bits, unsigned, with no wrap.
REQ-020 Among matches, the smallest py SHALL win; on equal py, the lower index SHALL win.
REQ-021 DONE SHALL last one cycle: done=1; hit, hit_idx and land_y=py of the winner are updated; then the FSM goes to IDLE.
REQ-022 Latency: start accepted at edge k -> busy=1 on cycles k+1..k+N+1 -> done=1 on cycle k+N+1.
REQ-023 hit, hit_idx, land_y and aborted SHALL hold until the next done; with no match, hit=0 and hit_idx/land_y=0.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 block_switch=1 in SCAN SHALL go to DONE next cycle with aborted=1, hit=0, hit_idx=0, land_y=0; aborted=0 on normal completion.
REQ-026 block_switch in IDLE or DONE SHALL have no effect; block_switch together with start in IDLE SHALL accept the start.

Reset
REQ-027 sys_rst=1 SHALL, at the next edge, force IDLE, idx=0, and busy=done=hit=aborted=0, hit_idx=0, land_y=0, regardless of state.
REQ-028 Reset mid-scan SHALL discard the scan with no done pulse; reset SHALL take priority over start.

Configuration
REQ-029 Macro PLAT_COLLIDE_HEAD_BUMP_EN defined SHALL add outputs bump (1) and bump_idx (3), updated at done alongside hit.
REQ-030 With the macro, a falling=0 scan SHALL set bump=1 when there is x overlap and py <= player_y < py+SNAP_TOL, with the lowest matching index; hit stays 0.
REQ-031 Without the macro, neither port SHALL exist and falling=0 SHALL always yield hit=0.

Verification
REQ-032 plat2 = (370,200,len 10); player (380,176), falling=1; start at cycle 0 -> done at cycle 8, hit=1, hit_idx=2, land_y=200.
REQ-033 plat1 = (100,300,8), plat4 = (100,304,8); player (120,280) (feet 304), falling=1 -> hit_idx=1, land_y=300.
REQ-034 x edge: plat0 x=280; player_x=264 -> hit=0; player_x=265 -> hit=1, hit_idx=0.
REQ-035 block_switch=1 at scan cycle 3 -> done one cycle later, aborted=1, hit=0; a start on that done cycle is ignored.
REQ-036 sys_rst=1 at scan cycle 4 -> no done, all outputs 0 next cycle; a new start afterwards completes in 8 cycles.
REQ-037 falling=0 with player (380,200) under plat2 -> hit=0; with the macro, bump=1, bump_idx=2.
